// File: rtl/mem_arbiter.sv
// Memory bus arbiter between instruction fetch and data access for the RV64 core.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed data-over-fetch priority.
module mem_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ireq_valid,
    input  logic [AW-1:0] ireq_addr,
    output logic          iresp_valid,
    output logic [31:0]   iresp_data,
    input  logic          dreq_valid,
    input  logic          dreq_we,
    input  logic [AW-1:0] dreq_addr,
    input  logic [2:0]    dreq_info,
    input  logic [DW-1:0] dreq_wdata,
    output logic          dresp_valid,
    output logic [DW-1:0] dresp_rdata,
    output logic          dresp_err,
    output logic          bus_valid,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [7:0]    bus_strb,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ready,
    input  logic [DW-1:0] bus_rdata
);
    // state | meaning
    // IDLE  | no grant; pick a winner among pending requests
    // BUS   | bus_valid high, waiting for bus_ready
    // RESP  | one-cycle response pulse to the winner
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t          state_q, state_d;
    logic            gnt_dat_q, gnt_dat_d;
    logic            i_pend_q, i_pend_d, d_pend_q, d_pend_d;
    logic [AW-1:0]   i_addr_q, i_addr_d, d_addr_q, d_addr_d;
    logic            d_we_q, d_we_d;
    logic [2:0]      d_info_q, d_info_d;
    logic [DW-1:0]   d_wdata_q, d_wdata_d;
    logic            bus_valid_q, bus_valid_d, bus_we_q, bus_we_d;
    logic [AW-1:0]   bus_addr_q, bus_addr_d;
    logic [7:0]      bus_strb_q, bus_strb_d;
    logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
    logic            iresp_valid_q, iresp_valid_d;
    logic [31:0]     iresp_data_q, iresp_data_d;
    logic            dresp_valid_q, dresp_valid_d, dresp_err_q, dresp_err_d;
    logic [DW-1:0]   dresp_rdata_q, dresp_rdata_d;
`ifdef ARB_RR_EN
    logic            last_grant_q, last_grant_d;   // 1 = data was granted last
`endif

    logic            i_take, d_take, i_pend_e, d_pend_e, pick_d, d_mis;
    logic [AW-1:0]   i_addr_e, d_addr_e;
    logic            d_we_e;
    logic [2:0]      d_info_e;
    logic [DW-1:0]   d_wdata_e, rd_sh, ld_ext;
    logic [7:0]      d_mask;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^i_addr_e[1:0];

    // A fresh pulse is visible to the grant logic in its own cycle so bus_valid follows one cycle later.
    always_comb begin
        i_take    = ireq_valid && !i_pend_q && !(state_q != S_IDLE && !gnt_dat_q);
        d_take    = dreq_valid && !d_pend_q && !(state_q != S_IDLE && gnt_dat_q);
        i_pend_e  = i_pend_q | i_take;
        d_pend_e  = d_pend_q | d_take;
        i_addr_e  = i_take ? ireq_addr  : i_addr_q;
        d_addr_e  = d_take ? dreq_addr  : d_addr_q;
        d_we_e    = d_take ? dreq_we    : d_we_q;
        d_info_e  = d_take ? dreq_info  : d_info_q;
        d_wdata_e = d_take ? dreq_wdata : d_wdata_q;
        d_mask    = 8'h01;
        d_mis     = 1'b0;
        case (d_info_e[1:0])
            2'd0: begin d_mask = 8'h01; d_mis = 1'b0;             end
            2'd1: begin d_mask = 8'h03; d_mis = d_addr_e[0];      end
            2'd2: begin d_mask = 8'h0F; d_mis = |d_addr_e[1:0];   end
            default: begin d_mask = 8'hFF; d_mis = |d_addr_e[2:0]; end
        endcase
        rd_sh  = bus_rdata >> {d_addr_q[2:0], 3'b000};
        ld_ext = rd_sh;
        case (d_info_q[1:0])
            2'd0: ld_ext = d_info_q[2] ? {56'd0, rd_sh[7:0]}  : {{56{rd_sh[7]}},  rd_sh[7:0]};
            2'd1: ld_ext = d_info_q[2] ? {48'd0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
            2'd2: ld_ext = d_info_q[2] ? {32'd0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
            default: ld_ext = rd_sh;
        endcase
`ifdef ARB_RR_EN
        pick_d = d_pend_e && (!i_pend_e || !last_grant_q);
`else
        pick_d = d_pend_e;
`endif
    end

    always_comb begin
        state_d       = state_q;
        gnt_dat_d     = gnt_dat_q;
        i_pend_d      = i_pend_e;
        d_pend_d      = d_pend_e;
        i_addr_d      = i_addr_e;
        d_addr_d      = d_addr_e;
        d_we_d        = d_we_e;
        d_info_d      = d_info_e;
        d_wdata_d     = d_wdata_e;
        bus_valid_d   = bus_valid_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_strb_d    = bus_strb_q;
        bus_wdata_d   = bus_wdata_q;
        iresp_valid_d = 1'b0;
        iresp_data_d  = iresp_data_q;
        dresp_valid_d = 1'b0;
        dresp_rdata_d = dresp_rdata_q;
        dresp_err_d   = dresp_err_q;
`ifdef ARB_RR_EN
        last_grant_d  = last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_d) begin
                    if (!d_mis) begin
                        state_d     = S_BUS;
                        gnt_dat_d   = 1'b1;
                        bus_valid_d = 1'b1;
                        bus_we_d    = d_we_e;
                        bus_addr_d  = {d_addr_e[AW-1:3], 3'b000};
                        bus_strb_d  = d_mask << d_addr_e[2:0];
                        bus_wdata_d = d_wdata_e << {d_addr_e[2:0], 3'b000};
`ifdef ARB_RR_EN
                        last_grant_d = 1'b1;
`endif
                    end else if (d_pend_q) begin
                        // Misaligned requests are answered from the latched copy: 2 cycles, no bus access.
                        state_d       = S_RESP;
                        gnt_dat_d     = 1'b1;
                        d_pend_d      = 1'b0;
                        dresp_valid_d = 1'b1;
                        dresp_err_d   = 1'b1;
                        dresp_rdata_d = '0;
`ifdef ARB_RR_EN
                        last_grant_d  = 1'b1;
`endif
                    end
                end else if (i_pend_e) begin
                    state_d     = S_BUS;
                    gnt_dat_d   = 1'b0;
                    bus_valid_d = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = {i_addr_e[AW-1:3], 3'b000};
                    bus_strb_d  = i_addr_e[2] ? 8'hF0 : 8'h0F;
                    bus_wdata_d = '0;
`ifdef ARB_RR_EN
                    last_grant_d = 1'b0;
`endif
                end
            end
            S_BUS: begin
                if (bus_ready) begin
                    state_d     = S_RESP;
                    bus_valid_d = 1'b0;
                    if (gnt_dat_q) begin
                        d_pend_d      = 1'b0;
                        dresp_valid_d = 1'b1;
                        dresp_err_d   = 1'b0;
                        dresp_rdata_d = d_we_q ? '0 : ld_ext;
                    end else begin
                        i_pend_d      = 1'b0;
                        iresp_valid_d = 1'b1;
                        iresp_data_d  = i_addr_q[2] ? bus_rdata[63:32] : bus_rdata[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            gnt_dat_q     <= 1'b0;
            i_pend_q      <= 1'b0;
            d_pend_q      <= 1'b0;
            i_addr_q      <= '0;
            d_addr_q      <= '0;
            d_we_q        <= 1'b0;
            d_info_q      <= '0;
            d_wdata_q     <= '0;
            bus_valid_q   <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_strb_q    <= '0;
            bus_wdata_q   <= '0;
            iresp_valid_q <= 1'b0;
            iresp_data_q  <= '0;
            dresp_valid_q <= 1'b0;
            dresp_rdata_q <= '0;
            dresp_err_q   <= 1'b0;
`ifdef ARB_RR_EN
            last_grant_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            gnt_dat_q     <= gnt_dat_d;
            i_pend_q      <= i_pend_d;
            d_pend_q      <= d_pend_d;
            i_addr_q      <= i_addr_d;
            d_addr_q      <= d_addr_d;
            d_we_q        <= d_we_d;
            d_info_q      <= d_info_d;
            d_wdata_q     <= d_wdata_d;
            bus_valid_q   <= bus_valid_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_strb_q    <= bus_strb_d;
            bus_wdata_q   <= bus_wdata_d;
            iresp_valid_q <= iresp_valid_d;
            iresp_data_q  <= iresp_data_d;
            dresp_valid_q <= dresp_valid_d;
            dresp_rdata_q <= dresp_rdata_d;
            dresp_err_q   <= dresp_err_d;
`ifdef ARB_RR_EN
            last_grant_q  <= last_grant_d;
`endif
        end
    end

    assign bus_valid   = bus_valid_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_strb    = bus_strb_q;
    assign bus_wdata   = bus_wdata_q;
    assign iresp_valid = iresp_valid_q;
    assign iresp_data  = iresp_data_q;
    assign dresp_valid = dresp_valid_q;
    assign dresp_rdata = dresp_rdata_q;
    assign dresp_err   = dresp_err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle-by-cycle checks of grants, strobes, load extension and reset abort.
// Expectations for simultaneous requests follow ARB_RR_EN when it is defined.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        dreq_valid;
    logic        dreq_we;
    logic [63:0] dreq_addr;
    logic [2:0]  dreq_info;
    logic [63:0] dreq_wdata;
    logic        dresp_valid;
    logic [63:0] dresp_rdata;
    logic        dresp_err;
    logic        bus_valid;
    logic        bus_we;
    logic [63:0] bus_addr;
    logic [7:0]  bus_strb;
    logic [63:0] bus_wdata;
    logic        bus_ready;
    logic [63:0] bus_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    mem_arbiter #(.AW(64), .DW(64)) dut (
        .clk(clk), .rst(rst),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_valid(iresp_valid), .iresp_data(iresp_data),
        .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_addr(dreq_addr),
        .dreq_info(dreq_info), .dreq_wdata(dreq_wdata),
        .dresp_valid(dresp_valid), .dresp_rdata(dresp_rdata), .dresp_err(dresp_err),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_strb(bus_strb), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic dpulse(input logic we, input logic [63:0] addr, input logic [2:0] info,
                          input logic [63:0] wdata);
        dreq_valid = 1'b1;
        dreq_we    = we;
        dreq_addr  = addr;
        dreq_info  = info;
        dreq_wdata = wdata;
    endtask

    initial begin
        rst = 1'b0; ireq_valid = 1'b0; ireq_addr = '0;
        dreq_valid = 1'b0; dreq_we = 1'b0; dreq_addr = '0; dreq_info = '0; dreq_wdata = '0;
        bus_ready = 1'b0; bus_rdata = '0;
        tick(); tick();
        chk("rst_bus_valid",   bus_valid,   1'b0);
        chk("rst_bus_strb",    bus_strb,    8'h00);
        chk("rst_iresp_valid", iresp_valid, 1'b0);
        chk("rst_dresp_valid", dresp_valid, 1'b0);
        chk("rst_dresp_rdata", dresp_rdata, 64'h0);
        rst = 1'b1;

        // fetch, zero-wait bus
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0004;
        bus_ready = 1'b1; bus_rdata = 64'h00000013_0000006F;
        tick(); ireq_valid = 1'b0;
        chk("f_bus_valid_c1", bus_valid, 1'b1);
        chk("f_bus_strb",     bus_strb,  8'hF0);
        chk("f_bus_we",       bus_we,    1'b0);
        chk("f_bus_addr",     bus_addr,  64'h8000_0000);
        tick();
        chk("f_iresp_valid_c2", iresp_valid, 1'b1);
        chk("f_iresp_data",     iresp_data,  32'h0000_0013);
        chk("f_bus_valid_c2",   bus_valid,   1'b0);
        tick();
        chk("f_iresp_pulse_end", iresp_valid, 1'b0);
        bus_ready = 1'b0;

        // lb with three wait cycles
        dpulse(1'b0, 64'h1003, 3'b000, 64'h0);
        bus_rdata = 64'h00000000_80000000;
        tick(); dreq_valid = 1'b0;
        chk("lb_bus_valid", bus_valid, 1'b1);
        chk("lb_bus_strb",  bus_strb,  8'h08);
        chk("lb_bus_addr",  bus_addr,  64'h1000);
        tick(); tick();
        chk("lb_bus_hold",  bus_valid, 1'b1);
        chk("lb_strb_hold", bus_strb,  8'h08);
        tick();
        bus_ready = 1'b1;
        chk("lb_no_early_resp", dresp_valid, 1'b0);
        tick(); bus_ready = 1'b0;
        chk("lb_dresp_valid", dresp_valid, 1'b1);
        chk("lb_dresp_rdata", dresp_rdata, 64'hFFFFFFFF_FFFFFF80);
        chk("lb_dresp_err",   dresp_err,   1'b0);
        tick();
        chk("lb_pulse_end", dresp_valid, 1'b0);

        // sh at offset 6
        dpulse(1'b1, 64'h2006, 3'b001, 64'h1234);
        bus_ready = 1'b1; bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        tick(); dreq_valid = 1'b0;
        chk("sh_bus_we",    bus_we,    1'b1);
        chk("sh_bus_strb",  bus_strb,  8'hC0);
        chk("sh_bus_wdata", bus_wdata, 64'h1234_0000_0000_0000);
        tick();
        chk("sh_dresp_valid", dresp_valid, 1'b1);
        chk("sh_dresp_rdata", dresp_rdata, 64'h0);
        tick();

        // simultaneous fetch and lw; repeated fetch pulse must be ignored
        dpulse(1'b0, 64'h3004, 3'b010, 64'h0);
        ireq_valid = 1'b1; ireq_addr = 64'h4000;
        bus_rdata = 64'hAABBCCDD_11223344;
        tick(); dreq_valid = 1'b0; ireq_addr = 64'h5000;
`ifdef ARB_RR_EN
        chk("sim_first_addr", bus_addr, 64'h4000);
        chk("sim_first_strb", bus_strb, 8'h0F);
`else
        chk("sim_first_addr", bus_addr, 64'h3000);
        chk("sim_first_strb", bus_strb, 8'hF0);
`endif
        tick(); ireq_valid = 1'b0;
`ifdef ARB_RR_EN
        chk("sim_first_iresp", iresp_valid, 1'b1);
        chk("sim_first_idata", iresp_data,  32'h1122_3344);
        chk("sim_first_dresp", dresp_valid, 1'b0);
`else
        chk("sim_first_dresp", dresp_valid, 1'b1);
        chk("sim_first_rdata", dresp_rdata, 64'hFFFFFFFF_AABBCCDD);
        chk("sim_first_iresp", iresp_valid, 1'b0);
`endif
        tick();
        chk("sim_gap", bus_valid, 1'b0);
        tick();
        chk("sim_second_valid", bus_valid, 1'b1);
`ifdef ARB_RR_EN
        chk("sim_second_addr", bus_addr, 64'h3000);
`else
        chk("sim_second_addr", bus_addr, 64'h4000);
        chk("sim_second_strb", bus_strb, 8'h0F);
`endif
        tick();
`ifdef ARB_RR_EN
        chk("sim_second_dresp", dresp_valid, 1'b1);
        chk("sim_second_rdata", dresp_rdata, 64'hFFFFFFFF_AABBCCDD);
`else
        chk("sim_second_iresp", iresp_valid, 1'b1);
        chk("sim_second_idata", iresp_data,  32'h1122_3344);
`endif
        tick();
        chk("sim_ignored_pulse", bus_valid, 1'b0);

        // misaligned lw; bus_ready stays high and must be ignored
        dpulse(1'b0, 64'h6002, 3'b010, 64'h0);
        tick(); dreq_valid = 1'b0;
        chk("mis_no_bus_c1", bus_valid,   1'b0);
        chk("mis_no_resp_c1", dresp_valid, 1'b0);
        tick();
        chk("mis_dresp_valid", dresp_valid, 1'b1);
        chk("mis_dresp_err",   dresp_err,   1'b1);
        chk("mis_dresp_rdata", dresp_rdata, 64'h0);
        chk("mis_no_bus_c2",   bus_valid,   1'b0);
        tick();
        chk("mis_pulse_end", dresp_valid, 1'b0);

        // reset while the bus is stalled
        bus_ready = 1'b0;
        dpulse(1'b0, 64'h7000, 3'b011, 64'h0);
        tick(); dreq_valid = 1'b0;
        chk("rb_bus_valid", bus_valid, 1'b1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1; bus_ready = 1'b1;
        chk("rb_bus_dropped", bus_valid, 1'b0);
        tick();
        chk("rb_no_resp_1", dresp_valid, 1'b0);
        tick();
        chk("rb_no_resp_2", dresp_valid, 1'b0);
        chk("rb_still_idle", bus_valid, 1'b0);

        // ld after reset
        dpulse(1'b0, 64'h8008, 3'b011, 64'h0);
        bus_rdata = 64'h01234567_89ABCDEF;
        tick(); dreq_valid = 1'b0;
        chk("ld_bus_addr", bus_addr, 64'h8008);
        chk("ld_bus_strb", bus_strb, 8'hFF);
        tick();
        chk("ld_dresp_valid", dresp_valid, 1'b1);
        chk("ld_dresp_rdata", dresp_rdata, 64'h01234567_89ABCDEF);
        tick();

        // lhu at offset 2, zero extension
        dpulse(1'b0, 64'h9002, 3'b101, 64'h0);
        bus_rdata = 64'h00000000_80010000;
        tick(); dreq_valid = 1'b0;
        chk("lhu_bus_strb", bus_strb, 8'h0C);
        tick();
        chk("lhu_dresp_rdata", dresp_rdata, 64'h0000_0000_0000_8001);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
